// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and sizes for the 16-channel mux scan controller.
// Pure declarations: no latency, no flow control.
package mux_scan_ctrl_pkg;

    localparam int N_CH  = 16;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Scan request, mux select/return and captured-word handshake bundle.
// master = controller side, slave = requester/consumer/mux side.
interface mux_scan_ctrl_if;
    import mux_scan_ctrl_pkg::*;

    logic             start;
    logic [SEL_W-1:0] sel;
    logic             mux_y;
    logic [N_CH-1:0]  data;
    logic             valid;
    logic             ready;
    logic             busy;

    modport master (
        input  start, mux_y, ready,
        output sel, data, valid, busy
    );

    modport slave (
        output start, mux_y, ready,
        input  sel, data, valid, busy
    );

endinterface

// File: rtl/mux_scan_timer.sv
// Settle counter (0..SETTLE-1) nested under a 4-bit channel counter.
// Strobes are combinational from the registered counts; no backpressure.
module mux_scan_timer
    import mux_scan_ctrl_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [SEL_W-1:0] chan_o,
    output logic             last_settle_o,
    output logic             last_chan_o
);

    localparam logic [1:0]       SETTLE_MAX = 2'(SETTLE - 1);
    localparam logic [SEL_W-1:0] CHAN_MAX   = SEL_W'(N_CH - 1);

    logic [1:0]       settle_q, settle_d;
    logic [SEL_W-1:0] chan_q, chan_d;

    assign last_settle_o = (settle_q == SETTLE_MAX);
    assign last_chan_o   = (chan_q == CHAN_MAX);
    assign chan_o        = chan_q;

    // Channel only advances on the last settle cycle, so sel never moves mid-settle.
    always_comb begin
        settle_d = settle_q;
        chan_d   = chan_q;
        if (clr_i) begin
            settle_d = '0;
            chan_d   = '0;
        end else if (en_i) begin
            if (last_settle_o) begin
                settle_d = '0;
                chan_d   = chan_q + 1'b1;
            end else begin
                settle_d = settle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q <= '0;
            chan_q   <= '0;
        end else begin
            settle_q <= settle_d;
            chan_q   <= chan_d;
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Walks sel 0..15 (SETTLE cycles each), captures mux_y per channel, presents the word.
// valid rises 16*SETTLE cycles after SCAN entry; word held in HOLD until valid&&ready.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_scan_ctrl_if.master bus
);

    state_e           state_q, state_d;
    logic [N_CH-1:0]  cap_q, cap_d;
    logic [N_CH-1:0]  data_q, data_d;
    logic             scan_go;
    logic [SEL_W-1:0] chan;
    logic             last_settle;
    logic             last_chan;

    mux_scan_timer #(.SETTLE(SETTLE)) u_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr_i         (scan_go),
        .en_i          (state_q == SCAN),
        .chan_o        (chan),
        .last_settle_o (last_settle),
        .last_chan_o   (last_chan)
    );

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        data_d  = data_q;
        scan_go = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    scan_go = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (last_settle) begin
                    cap_d[chan] = bus.mux_y;
                    if (last_chan) begin
                        data_d  = cap_d;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.ready) begin
                    scan_go = bus.start;
                    state_d = bus.start ? SCAN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Fresh capture per scan so no bit survives from the previous word.
        if (scan_go) begin
            cap_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cap_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            data_q  <= data_d;
        end
    end

    assign bus.sel   = (state_q == SCAN) ? chan : '0;
    assign bus.data  = data_q;
    assign bus.valid = (state_q == HOLD);
    assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Two controllers (SETTLE=1 and SETTLE=3) scanning behavioural 16x1 muxes.
// Expected sel/valid/data come from cycle arithmetic on the scan rules.
module tb_mux_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a0, a1;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    mux_scan_ctrl_if if0 ();
    mux_scan_ctrl_if if1 ();

    assign if0.mux_y = a0[if0.sel];
    assign if1.mux_y = a1[if1.sel];

    mux_scan_ctrl #(.SETTLE(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    mux_scan_ctrl #(.SETTLE(3)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_start(input int d, input logic v);
        if (d == 0) if0.start = v; else if1.start = v;
    endtask

    task automatic drive_ready(input int d, input logic v);
        if (d == 0) if0.ready = v; else if1.ready = v;
    endtask

    task automatic set_pat(input int d, input logic [15:0] p);
        if (d == 0) a0 = p; else a1 = p;
    endtask

    task automatic sample(input int d, output logic [3:0] s, output logic [15:0] dt,
                          output logic v, output logic b);
        if (d == 0) begin
            s = if0.sel; dt = if0.data; v = if0.valid; b = if0.busy;
        end else begin
            s = if1.sel; dt = if1.data; v = if1.valid; b = if1.busy;
        end
    endtask

    // Call with start already driven for the coming edge; returns at the negedge in HOLD.
    task automatic scan_body(input int d, input int s_cyc, input logic [15:0] pat,
                             input bit keep_start, input bit accept);
        logic [3:0]  s;
        logic [15:0] dt;
        logic        v, b;
        for (int k = 0; k < 16 * s_cyc; k++) begin
            @(negedge clk);
            if (k == 0 && !keep_start) drive_start(d, 1'b0);
            sample(d, s, dt, v, b);
            chk("scan_sel",   {28'd0, s}, k / s_cyc);
            chk("scan_valid", {31'd0, v}, 0);
            chk("scan_busy",  {31'd0, b}, 1);
        end
        @(negedge clk);
        sample(d, s, dt, v, b);
        chk("hold_valid", {31'd0, v}, 1);
        chk("hold_data",  {16'd0, dt}, {16'd0, pat});
        chk("hold_sel",   {28'd0, s}, 0);
        chk("hold_busy",  {31'd0, b}, 1);
        if (accept) begin
            @(negedge clk);
            sample(d, s, dt, v, b);
            chk("acc_valid", {31'd0, v}, 0);
            chk("acc_busy",  {31'd0, b}, 0);
            chk("acc_data",  {16'd0, dt}, {16'd0, pat});
        end
    endtask

    // Stall in HOLD for dly cycles (start may toggle, must be ignored), then accept.
    task automatic hold_then_accept(input int d, input logic [15:0] pat, input int dly,
                                    input bit rand_start);
        logic [3:0]  s;
        logic [15:0] dt;
        logic        v, b;
        for (int j = 0; j < dly; j++) begin
            drive_start(d, rand_start ? 1'($urandom_range(0, 1)) : 1'b1);
            @(negedge clk);
            sample(d, s, dt, v, b);
            chk("stall_valid", {31'd0, v}, 1);
            chk("stall_data",  {16'd0, dt}, {16'd0, pat});
            chk("stall_busy",  {31'd0, b}, 1);
        end
        drive_start(d, 1'b0);
        drive_ready(d, 1'b1);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            sample(d, s, dt, v, b);
            chk("idle_valid", {31'd0, v}, 0);
            chk("idle_busy",  {31'd0, b}, 0);
            chk("idle_sel",   {28'd0, s}, 0);
            chk("idle_data",  {16'd0, dt}, {16'd0, pat});
        end
    endtask

    initial begin
        logic [3:0]  s;
        logic [15:0] dt, pat;
        logic        v, b;
        int          d;

        rst_n = 1'b0;
        a0 = 16'h0; a1 = 16'h0;
        drive_start(0, 1'b0); drive_start(1, 1'b0);
        drive_ready(0, 1'b1); drive_ready(1, 1'b1);
        #1;
        for (int i = 0; i < 2; i++) begin
            sample(i, s, dt, v, b);
            chk("rst_sel",   {28'd0, s}, 0);
            chk("rst_data",  {16'd0, dt}, 0);
            chk("rst_valid", {31'd0, v}, 0);
            chk("rst_busy",  {31'd0, b}, 0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic scan, SETTLE=1
        @(negedge clk);
        a0 = 16'hA5C3;
        drive_start(0, 1'b1);
        scan_body(0, 1, 16'hA5C3, 1'b0, 1'b1);

        // Consumer stalls 5 cycles with start held in HOLD
        drive_ready(0, 1'b0);
        @(negedge clk);
        drive_start(0, 1'b1);
        scan_body(0, 1, 16'hA5C3, 1'b0, 1'b0);
        hold_then_accept(0, 16'hA5C3, 5, 1'b0);

        // Reset while sel==7 aborts the scan
        @(negedge clk);
        a0 = 16'h5A5A;
        drive_start(0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) drive_start(0, 1'b0);
        end
        sample(0, s, dt, v, b);
        chk("pre_rst_sel", {28'd0, s}, 7);
        #2 rst_n = 1'b0;
        #1;
        sample(0, s, dt, v, b);
        chk("arst_sel",   {28'd0, s}, 0);
        chk("arst_data",  {16'd0, dt}, 0);
        chk("arst_valid", {31'd0, v}, 0);
        chk("arst_busy",  {31'd0, b}, 0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            sample(0, s, dt, v, b);
            chk("abort_valid", {31'd0, v}, 0);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        a0 = 16'h3C0F;
        drive_start(0, 1'b1);
        scan_body(0, 1, 16'h3C0F, 1'b0, 1'b1);

        // SETTLE=3
        @(negedge clk);
        a1 = 16'h0001;
        drive_start(1, 1'b1);
        scan_body(1, 3, 16'h0001, 1'b0, 1'b1);

        // Back-to-back on both settle settings
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_pat(i, 16'hFFFF);
            drive_ready(i, 1'b1);
            drive_start(i, 1'b1);
            scan_body(i, i == 0 ? 1 : 3, 16'hFFFF, 1'b1, 1'b0);
            set_pat(i, 16'h0000);
            scan_body(i, i == 0 ? 1 : 3, 16'h0000, 1'b0, 1'b1);
        end

        // Random patterns, random controller, random stall length
        for (int n = 0; n < 8; n++) begin
            d   = int'($urandom_range(0, 1));
            pat = 16'($urandom);
            @(negedge clk);
            set_pat(d, pat);
            drive_ready(d, 1'b0);
            drive_start(d, 1'b1);
            scan_body(d, d == 0 ? 1 : 3, pat, 1'b0, 1'b0);
            set_pat(d, ~pat);
            hold_then_accept(d, pat, int'($urandom_range(0, 4)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter SETTLE, default 1: clock cycles each select value is held before mux output is sampled; legal range 1..4.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  scan request; sampled only in IDLE.
REQ-005 sel  output  4  select driven to downstream 16x1 mux.
REQ-006 mux_y  input  1  single-bit output returned from the 16x1 mux.
REQ-007 data  output  16  captured word; bit i = mux_y sampled while sel==i.
REQ-008 valid  output  1  data holds a complete captured word.
REQ-009 ready  input  1  consumer accepts data when valid&&ready.
REQ-010 busy  output  1  high in SCAN and HOLD.

Function
REQ-011 States IDLE, SCAN, HOLD; state is registered.
REQ-012 IDLE: sel=0, valid=0, busy=0; start=1 at an edge -> SCAN, channel index=0, settle count=0.
REQ-013 SCAN: sel equals registered channel index; index changes only at channel boundaries, never mid-settle.
REQ-014 Each channel occupies exactly SETTLE cycles; mux_y sampled at the edge ending the channel's last cycle into capture bit [index].
REQ-015 After channel 15 sampled: capture word copied to data, valid=1, state -> HOLD, sel -> 0.
REQ-016 Latency: valid rises exactly 16*SETTLE cycles after the first SCAN cycle; sel sequence 0,1,...,15, each value held SETTLE cycles.
REQ-017 HOLD: data and valid stable until valid&&ready at an edge.
REQ-018 valid&&ready with start=0 -> IDLE, valid=0 next cycle.
REQ-019 valid&&ready with start=1 same edge -> SCAN directly (back-to-back), index=0, valid=0 next cycle.
REQ-020 start while in SCAN or in HOLD without ready: ignored, no queuing.
REQ-021 data updated only on the SCAN->HOLD transition; retains last word in IDLE.
REQ-022 Capture register cleared on each SCAN entry; no bit leaks from a previous scan.

Reset
REQ-023 rst_n=0 immediately forces state=IDLE, sel=0, data=0, valid=0, busy=0, index=0, settle count=0, capture=0, independent of clk.
REQ-024 Reset mid-scan aborts the scan; valid does not rise for the aborted word.
REQ-025 First start after rst_n deasserts is honoured on the first edge with rst_n=1.

Structure
REQ-026 Shared package holds state enum (IDLE, SCAN, HOLD), N_CH=16, SEL_W=4.
REQ-027 One sub-module, mux_scan_timer: settle counter plus 4-bit channel counter, outputs chan and last_chan/last_settle strobes.
REQ-028 The 16x1 mux itself is not instantiated inside this block; it sits downstream on sel and returns mux_y.

Verification
REQ-029 Bench drives a behavioural 16x1 mux from sel with pattern a; SETTLE=1, a=16'hA5C3, one start pulse, ready=1 -> sel 0..15 one cycle each, valid for one cycle 16 cycles after SCAN entry, data=16'hA5C3.
REQ-030 ready low 5 cycles after valid, start pulsed in HOLD -> valid, data=16'hA5C3, busy held constant; no new scan after acceptance.
REQ-031 rst_n low while sel==7 -> all outputs 0 immediately, valid never rises; next start with a=16'h3C0F -> data=16'h3C0F.
REQ-032 SETTLE=3, a=16'h0001 -> each sel value held 3 cycles, valid 48 cycles after SCAN entry, data=16'h0001.
REQ-033 Back-to-back: a=16'hFFFF, start held high, ready=1, a switched to 16'h0000 at first HOLD -> words 16'hFFFF then 16'h0000, one valid cycle apart by 16*SETTLE+1 cycles, sel never idles.
